// File: rtl/noc_flit_demux.sv
// Registered 1-to-NUM_OUT flit demultiplexer with head-to-tail route locking.
// Each output port owns a one-entry register; malformed packets are dropped with an err pulse.
module noc_flit_demux #(
  parameter int DATA_W  = 32,
  parameter int NUM_OUT = 5,
  parameter int SEL_W   = $clog2(NUM_OUT)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [DATA_W-1:0]         in_data,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [SEL_W-1:0]          in_sel,
  input  logic                      in_head,
  input  logic                      in_tail,
  output logic [NUM_OUT*DATA_W-1:0] out_data,
  output logic [NUM_OUT-1:0]        out_valid,
  input  logic [NUM_OUT-1:0]        out_ready,
  output logic                      busy,
  output logic                      err
);

  typedef enum logic [1:0] {IDLE, LOCKED, DROP} state_t;

  localparam logic [SEL_W:0] PORT_LIMIT = (SEL_W+1)'(NUM_OUT);

  state_t             state;
  logic [SEL_W-1:0]   route;
  logic [SEL_W-1:0]   target;
  logic               sel_ok;
  logic               bypass;
  logic               target_blocked;
  logic               accept;
  logic               forward;
  logic [NUM_OUT-1:0] load;
  logic [DATA_W-1:0]  data_q [NUM_OUT];

  assign sel_ok  = {1'b0, in_sel} < PORT_LIMIT;
  assign target  = (state == LOCKED) ? route : in_sel;
  // Flits that will be discarded never wait on a port register.
  assign bypass  = (state == DROP) || ((state == IDLE) && (!in_head || !sel_ok));
  assign forward = (state == LOCKED) || ((state == IDLE) && in_head && sel_ok);

  always_comb begin
    target_blocked = 1'b0;
    for (int p = 0; p < NUM_OUT; p++) begin
      if (target == SEL_W'(p)) target_blocked = out_valid[p] && !out_ready[p];
    end
  end

  assign in_ready = bypass || !target_blocked;
  assign accept   = in_valid && in_ready;

  always_comb begin
    load = '0;
    for (int p = 0; p < NUM_OUT; p++) begin
      load[p] = accept && forward && (target == SEL_W'(p));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      route <= '0;
      err   <= 1'b0;
    end else begin
      err <= 1'b0;
      if (accept) begin
        case (state)
          IDLE: begin
            if (in_head && sel_ok) begin
              if (!in_tail) begin
                state <= LOCKED;
                route <= in_sel;
              end
            end else if (in_head) begin
              err <= 1'b1;
              if (!in_tail) state <= DROP;
            end else begin
              err <= 1'b1;
            end
          end
          LOCKED: if (in_tail) state <= IDLE;
          DROP:   if (in_tail) state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign busy = (state != IDLE);

  // A load wins over a drain so a same-cycle refill keeps the port valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= '0;
      for (int p = 0; p < NUM_OUT; p++) data_q[p] <= '0;
    end else begin
      for (int p = 0; p < NUM_OUT; p++) begin
        if (load[p]) begin
          data_q[p]    <= in_data;
          out_valid[p] <= 1'b1;
        end else if (out_ready[p]) begin
          out_valid[p] <= 1'b0;
        end
      end
    end
  end

  for (genvar g = 0; g < NUM_OUT; g++) begin : g_out
    assign out_data[g*DATA_W +: DATA_W] = data_q[g];
  end

endmodule

// File: tb/tb_noc_flit_demux.sv
// Bench for noc_flit_demux: table of flit vectors plus hand sequences for backpressure and reset,
// with per-port scoreboard queues driven by a behavioural model of the demux.
module tb_noc_flit_demux;

  localparam int DW = 32;
  localparam int NO = 5;

  logic           clk;
  logic           rst_n;
  logic [DW-1:0]  in_data;
  logic           in_valid;
  logic           in_ready;
  logic [2:0]     in_sel;
  logic           in_head;
  logic           in_tail;
  logic [NO*DW-1:0] out_data;
  logic [NO-1:0]  out_valid;
  logic [NO-1:0]  out_ready;
  logic           busy;
  logic           err;

  typedef struct {
    logic        head;
    logic        tail;
    logic [2:0]  sel;
    logic [31:0] data;
    int          port;
    logic        exp_err;
    logic        exp_busy;
  } vec_t;

  int   checks = 0;
  int   errors = 0;
  vec_t vecs [14];
  vec_t pend_v;
  logic pend = 1'b0;

  // Model state: 0 idle, 1 locked, 2 drop; port queues hold at most one flit each.
  int          m_state = 0;
  int          m_route = 0;
  logic        m_err = 1'b0;
  logic [31:0] q [NO][$];

  noc_flit_demux dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .in_sel(in_sel), .in_head(in_head), .in_tail(in_tail), .out_data(out_data),
    .out_valid(out_valid), .out_ready(out_ready), .busy(busy), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic h, input logic t, input logic [2:0] s,
                              input logic [31:0] d, input int p, input logic e, input logic b);
    vec_t v;
    v.head = h; v.tail = t; v.sel = s; v.data = d; v.port = p; v.exp_err = e; v.exp_busy = b;
    return v;
  endfunction

  // Drive one flit (entered just after a rising edge) and hold it until accepted.
  task automatic applyStimulus(input vec_t v);
    logic got;
    got = 1'b0;
    in_valid = 1'b1;
    in_head  = v.head;
    in_tail  = v.tail;
    in_sel   = v.sel;
    in_data  = v.data;
    for (int c = 0; c < 20 && !got; c++) begin
      @(negedge clk);
      if (in_ready) got = 1'b1;
      @(posedge clk);
      #1;
    end
    if (!got) begin
      checks++;
      errors++;
      $display("[TB] FAIL accept_timeout actual=no-accept expected=accept data=%h", v.data);
    end else begin
      pend_v = v;
      pend   = 1'b1;
    end
  endtask

  task automatic idleCycles(input int n);
    in_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Behavioural model and scoreboard, evaluated mid-cycle while inputs are stable.
  always @(negedge clk) begin
    int   tgt;
    logic ok;
    logic exp_ready;
    if (!rst_n) begin
      m_state = 0;
      m_route = 0;
      m_err   = 1'b0;
      for (int p = 0; p < NO; p++) q[p].delete();
      checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
      checkOutput("rst_busy", 32'(busy), 32'd0);
    end else begin
      if (pend) begin
        checkOutput("vec_err", 32'(err), 32'(pend_v.exp_err));
        checkOutput("vec_busy", 32'(busy), 32'(pend_v.exp_busy));
        if (pend_v.port >= 0) begin
          checkOutput("vec_port_valid", 32'(out_valid[pend_v.port]), 32'd1);
          checkOutput("vec_port_data", out_data[pend_v.port*DW +: DW], pend_v.data);
        end
        pend = 1'b0;
      end
      ok  = (int'(in_sel) < NO);
      tgt = (m_state == 1) ? m_route : int'(in_sel);
      if (m_state == 2 || (m_state == 0 && (!in_head || !ok))) exp_ready = 1'b1;
      else exp_ready = !(q[tgt].size() != 0 && !out_ready[tgt]);
      checkOutput("in_ready", 32'(in_ready), 32'(exp_ready));
      checkOutput("busy", 32'(busy), 32'(m_state != 0));
      checkOutput("err", 32'(err), 32'(m_err));
      for (int p = 0; p < NO; p++) begin
        checkOutput("out_valid", 32'(out_valid[p]), 32'(q[p].size() != 0));
        if (q[p].size() != 0) begin
          checkOutput("out_data", out_data[p*DW +: DW], q[p][0]);
          if (out_ready[p]) void'(q[p].pop_front());
        end
      end
      m_err = 1'b0;
      if (in_valid && exp_ready) begin
        case (m_state)
          0: begin
            if (in_head && ok) begin
              q[in_sel].push_back(in_data);
              if (!in_tail) begin
                m_state = 1;
                m_route = int'(in_sel);
              end
            end else begin
              m_err = 1'b1;
              if (in_head && !in_tail) m_state = 2;
            end
          end
          1: begin
            q[m_route].push_back(in_data);
            if (in_tail) m_state = 0;
          end
          default: if (in_tail) m_state = 0;
        endcase
      end
    end
  end

  initial begin
    rst_n = 1'b1; in_valid = 1'b0; in_head = 1'b0; in_tail = 1'b0;
    in_sel = 3'd0; in_data = '0; out_ready = '1;
    #1 rst_n = 1'b0;
    #1;
    checkOutput("reset_out_valid", 32'(out_valid), 32'd0);
    checkOutput("reset_busy", 32'(busy), 32'd0);
    checkOutput("reset_err", 32'(err), 32'd0);
    checkOutput("reset_out_data", 32'(|out_data), 32'd0);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;

    vecs[0]  = mk(1, 1, 3'd3, 32'hA5A5_0001,  3, 0, 0);
    vecs[1]  = mk(1, 0, 3'd1, 32'h1111_0001,  1, 0, 1);
    vecs[2]  = mk(0, 0, 3'd0, 32'h1111_0002,  1, 0, 1);
    vecs[3]  = mk(1, 0, 3'd4, 32'h1111_0003,  1, 0, 1);
    vecs[4]  = mk(0, 1, 3'd2, 32'h1111_0004,  1, 0, 0);
    vecs[5]  = mk(1, 0, 3'd6, 32'hDEAD_0001, -1, 1, 1);
    vecs[6]  = mk(0, 0, 3'd1, 32'hDEAD_0002, -1, 0, 1);
    vecs[7]  = mk(0, 0, 3'd2, 32'hDEAD_0003, -1, 0, 1);
    vecs[8]  = mk(0, 1, 3'd0, 32'hDEAD_0004, -1, 0, 0);
    vecs[9]  = mk(0, 0, 3'd2, 32'hBAD0_0001, -1, 1, 0);
    vecs[10] = mk(1, 1, 3'd2, 32'hC0DE_0002,  2, 0, 0);
    vecs[11] = mk(1, 1, 3'd7, 32'hBAD0_0002, -1, 1, 0);
    vecs[12] = mk(1, 0, 3'd0, 32'hC0DE_0003,  0, 0, 1);
    vecs[13] = mk(0, 1, 3'd3, 32'hC0DE_0004,  0, 0, 0);
    for (int i = 0; i < 14; i++) applyStimulus(vecs[i]);
    idleCycles(2);

    // Port 2 stalls; another port still accepts a packet while IDLE.
    out_ready = 5'b11011;
    applyStimulus(mk(1, 1, 3'd2, 32'h2222_0001, 2, 0, 0));
    applyStimulus(mk(1, 1, 3'd0, 32'h0000_0002, 0, 0, 0));
    in_valid = 1'b1; in_head = 1'b1; in_tail = 1'b0; in_sel = 3'd2; in_data = 32'h2222_0003;
    repeat (3) begin
      @(negedge clk);
      checkOutput("bp_in_ready", 32'(in_ready), 32'd0);
      checkOutput("bp_hold", out_data[2*DW +: DW], 32'h2222_0001);
    end
    @(posedge clk);
    #1 out_ready = '1;
    applyStimulus(mk(1, 0, 3'd2, 32'h2222_0003, 2, 0, 1));
    applyStimulus(mk(0, 0, 3'd4, 32'h2222_0004, 2, 0, 1));
    applyStimulus(mk(0, 1, 3'd1, 32'h2222_0005, 2, 0, 0));
    idleCycles(2);

    // Reset mid-packet with a flit parked on port 4.
    out_ready = 5'b01111;
    applyStimulus(mk(1, 0, 3'd4, 32'h4444_0001, 4, 0, 1));
    in_valid = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("async_rst_valid", 32'(out_valid), 32'd0);
    checkOutput("async_rst_busy", 32'(busy), 32'd0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1 out_ready = '1;
    applyStimulus(mk(1, 1, 3'd0, 32'h0000_F001, 0, 0, 0));
    idleCycles(3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
